// File: rtl/imem_pkg.sv
// Shared constants, state encoding and address checking for the instruction
// memory controller and its RAM.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH = 1024;
  localparam int unsigned IMEM_AW    = $clog2(IMEM_DEPTH);

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } imem_state_t;

  // A byte address is usable only if word aligned and inside a 2**aw word RAM.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned aw);
    return (addr[1:0] == 2'b00) && ((addr >> (aw + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/imem_sram.sv
// Single-port synchronous instruction RAM: write-through disabled, read data
// appears the cycle after an enabled read. The array is not reset.
module imem_sram
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          m_en,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [31:0]   m_wdata,
  output logic [31:0]   m_rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (m_en) begin
      if (m_we) begin
        mem_q[m_addr] <= m_wdata;
      end else begin
        rdata_q <= mem_q[m_addr];
      end
    end
  end

  assign m_rdata = rdata_q;

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction RAM between CPU fetch and the program
// loader: loader-only during BOOT, fetch-priority with a starvation bound in RUN.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH      = IMEM_DEPTH,
  parameter int unsigned AW         = $clog2(DEPTH),
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  output logic          f_err,
  input  logic          l_valid,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_ready,
  input  logic          ld_done,
  output logic          cpu_hold,
  output logic [AW:0]   ld_count,
  output logic          ld_err,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  localparam int unsigned SW      = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX  = SW'(STARVE_MAX);
  localparam logic [AW:0]   CMAX  = (AW + 1)'(DEPTH);

  imem_state_t   state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [AW:0]   ld_count_q, ld_count_d;
  logic          ld_err_q, ld_err_d;
  logic          pend_q, pend_d;
  logic          perr_q, perr_d;

  logic f_ok, l_ok, force_ld, f_win, l_win;

  assign f_ok     = addr_ok(f_addr, AW);
  assign l_ok     = addr_ok(l_addr, AW);
  assign force_ld = (starve_q == SMAX);

  always_comb begin
    state_d    = state_q;
    starve_d   = '0;
    ld_count_d = ld_count_q;
    ld_err_d   = ld_err_q;
    f_win      = 1'b0;
    l_win      = 1'b0;
    l_ready    = 1'b0;
    f_gnt      = 1'b0;
    m_en       = 1'b0;
    m_we       = 1'b0;
    m_addr     = f_addr[AW+1:2];
    m_wdata    = l_wdata;

    if (state_q == BOOT) begin
      l_ready = 1'b1;
      l_win   = l_valid;
      if (ld_done) begin
        state_d = RUN;
      end
    end else begin
      f_win = f_req && !(l_valid && force_ld);
      l_win = l_valid && !f_win;
      l_ready = l_win;
      f_gnt   = f_win;
      if (f_win && l_valid) begin
        starve_d = starve_q + 1'b1;
      end
    end

    if (l_win) begin
      if (l_ok) begin
        m_en    = 1'b1;
        m_we    = 1'b1;
        m_addr  = l_addr[AW+1:2];
        if (ld_count_q != CMAX) begin
          ld_count_d = ld_count_q + 1'b1;
        end
      end else begin
        ld_err_d = 1'b1;
      end
    end else if (f_win && f_ok) begin
      m_en = 1'b1;
    end

    // Outputs must read as idle while reset is held, even though BOOT is active.
    if (reset) begin
      l_ready = 1'b0;
      f_gnt   = 1'b0;
      m_en    = 1'b0;
      m_we    = 1'b0;
    end
  end

  assign pend_d = f_win;
  assign perr_d = f_win && !f_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= BOOT;
      starve_q   <= '0;
      ld_count_q <= '0;
      ld_err_q   <= 1'b0;
      pend_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      ld_count_q <= ld_count_d;
      ld_err_q   <= ld_err_d;
      pend_q     <= pend_d;
      perr_q     <= perr_d;
    end
  end

  assign cpu_hold = (state_q == BOOT);
  assign ld_count = ld_count_q;
  assign ld_err   = ld_err_q;
  assign f_rvalid = pend_q;
  assign f_err    = pend_q && perr_q;
  assign f_rdata  = !pend_q ? 32'h0 : (perr_q ? NOP_INSN : m_rdata);

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed checks of the instruction memory arbiter with the RAM beside it.
module tb_imem_arbiter;
  import imem_pkg::*;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req, l_valid, ld_done;
  logic [31:0]   f_addr, l_addr, l_wdata;
  logic          f_gnt, f_rvalid, f_err, l_ready, cpu_hold, ld_err;
  logic [31:0]   f_rdata, m_wdata, m_rdata;
  logic [AW:0]   ld_count;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.DEPTH(1024), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .l_valid(l_valid), .l_addr(l_addr), .l_wdata(l_wdata), .l_ready(l_ready),
    .ld_done(ld_done), .cpu_hold(cpu_hold), .ld_count(ld_count), .ld_err(ld_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  imem_sram #(.DEPTH(1024)) u_ram (
    .clk(clk), .m_en(m_en), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge; drives happen here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] img_a [3] = '{32'h0, 32'h4, 32'h8};
  logic [31:0] img_d [3] = '{32'h00500113, 32'h00A00193, 32'h002081B3};

  initial begin
    reset = 1'b1; f_req = 0; l_valid = 0; ld_done = 0;
    f_addr = 0; l_addr = 0; l_wdata = 0;
    #3;
    check("rst cpu_hold", {31'h0, cpu_hold}, 32'd1);
    check("rst f_rvalid", {31'h0, f_rvalid}, 32'd0);
    check("rst l_ready", {31'h0, l_ready}, 32'd0);
    check("rst f_rdata", f_rdata, 32'h0);
    step();
    reset = 1'b0;
    #1;
    check("boot l_ready", {31'h0, l_ready}, 32'd1);
    check("boot ld_count", 32'(ld_count), 32'd0);

    // BOOT image load; fetch request held to prove it is never granted
    for (int i = 0; i < 3; i++) begin
      step();
      l_valid = 1; l_addr = img_a[i]; l_wdata = img_d[i]; f_req = 1; f_addr = 32'h0;
      #1;
      check($sformatf("boot wr%0d m_en/we", i), {30'h0, m_en, m_we}, 32'd3);
      check($sformatf("boot wr%0d m_addr", i), 32'(m_addr), img_a[i] >> 2);
      check($sformatf("boot wr%0d f_gnt", i), {31'h0, f_gnt}, 32'd0);
    end
    step();
    l_valid = 0; f_req = 0; ld_done = 1;
    #1;
    check("ld_count after image", 32'(ld_count), 32'd3);
    check("hold before done edge", {31'h0, cpu_hold}, 32'd1);
    step();
    ld_done = 0;
    check("hold after done edge", {31'h0, cpu_hold}, 32'd0);

    // Back-to-back fetches
    for (int i = 0; i < 3; i++) begin
      f_req = 1; f_addr = img_a[i];
      #1;
      check($sformatf("fetch%0d f_gnt", i), {31'h0, f_gnt}, 32'd1);
      check($sformatf("fetch%0d m_en/we", i), {30'h0, m_en, m_we}, 32'd2);
      step();
      check($sformatf("fetch%0d rvalid", i), {31'h0, f_rvalid}, 32'd1);
      check($sformatf("fetch%0d rdata", i), f_rdata, img_d[i]);
      check($sformatf("fetch%0d err", i), {31'h0, f_err}, 32'd0);
    end
    f_req = 0;
    step();
    check("fetch idle rvalid", {31'h0, f_rvalid}, 32'd0);

    // Contention: loader wins only on the fifth cycle
    for (int i = 0; i < 8; i++) begin
      f_req = 1; f_addr = 32'h0;
      l_valid = 1; l_addr = 32'h10; l_wdata = 32'hDEAD0000 + i;
      #1;
      check($sformatf("starve c%0d f_gnt", i), {31'h0, f_gnt}, {31'h0, i != 4});
      check($sformatf("starve c%0d l_ready", i), {31'h0, l_ready}, {31'h0, i == 4});
      check($sformatf("starve c%0d m_en/we", i), {30'h0, m_en, m_we}, (i == 4) ? 32'd3 : 32'd2);
      step();
    end
    f_req = 0; l_valid = 0;
    #1;
    check("ld_count after starve", 32'(ld_count), 32'd4);
    f_req = 1; f_addr = 32'h10;
    step();
    f_req = 0;
    check("readback starve wr", f_rdata, 32'hDEAD0004);

    // Bad fetches
    f_addr = 32'h2; f_req = 1;
    #1;
    check("misalign f_gnt", {31'h0, f_gnt}, 32'd1);
    check("misalign m_en", {31'h0, m_en}, 32'd0);
    step();
    f_addr = 32'h1000;
    check("misalign rsp", {30'h0, f_rvalid, f_err}, 32'd3);
    check("misalign nop", f_rdata, NOP_INSN);
    #1;
    check("range f_gnt", {31'h0, f_gnt}, 32'd1);
    check("range m_en", {31'h0, m_en}, 32'd0);
    step();
    f_req = 0;
    check("range rsp", {30'h0, f_rvalid, f_err}, 32'd3);
    check("range nop", f_rdata, NOP_INSN);

    // Bad loader write, and ld_done ignored in RUN
    l_valid = 1; l_addr = 32'h0000_1004; l_wdata = 32'h12345678; ld_done = 1;
    #1;
    check("bad wr l_ready", {31'h0, l_ready}, 32'd1);
    check("bad wr m_en", {31'h0, m_en}, 32'd0);
    step();
    l_valid = 0; ld_done = 0;
    check("bad wr ld_err", {31'h0, ld_err}, 32'd1);
    check("bad wr ld_count", 32'(ld_count), 32'd4);
    step();
    check("ld_err sticky", {31'h0, ld_err}, 32'd1);
    check("run hold after ld_done", {31'h0, cpu_hold}, 32'd0);

    // Reset with a fetch in flight
    f_req = 1; f_addr = 32'h4;
    step();
    f_req = 0;
    check("inflight rvalid", {31'h0, f_rvalid}, 32'd1);
    reset = 1;
    #1;
    check("async rst rvalid", {31'h0, f_rvalid}, 32'd0);
    check("async rst hold", {31'h0, cpu_hold}, 32'd1);
    step();
    reset = 0;
    #1;
    check("post rst ld_count", 32'(ld_count), 32'd0);
    check("post rst ld_err", {31'h0, ld_err}, 32'd0);
    check("post rst l_ready", {31'h0, l_ready}, 32'd1);
    check("post rst rvalid", {31'h0, f_rvalid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
